// File: rtl/approx_pkg.sv
// approx_pkg: shared types and helpers for the approximation-unit arbiter.
//   state_e     arbiter FSM encoding (IDLE/ISSUE/WAIT/DELIVER)
//   DATA_W_DEF  default operand/result width
//   IT_W_DEF    default iteration-count width
//   clog2()     ceiling log2 usable in constant expressions
package approx_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IT_W_DEF   = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_e;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i  in   NUM_REQ         request vector
//   ptr_i  in   clog2(NUM_REQ)  highest-priority index (must be < NUM_REQ)
//   gnt_c  out  NUM_REQ         one-hot grant of the first request at/after ptr_i
//   idx_c  out  clog2(NUM_REQ)  index of the granted request
//   any_c  out  1               at least one request present
module rr_arbiter
  import approx_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]        gnt_c,
  output logic [clog2(NUM_REQ)-1:0] idx_c,
  output logic                      any_c
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan from the pointer with explicit modulo wrap so non power-of-2 counts work.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

  assign any_c = |req_i;

endmodule

// File: rtl/approx_arbiter.sv
// approx_arbiter: round-robin sharing of one approximation unit among NUM_REQ clients.
// Optional watchdog: define APPROX_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles.
//   clk, rst        clock, async active-high reset
//   req_i           per-requester level request (held until ack_o)
//   x_i, nit_i      packed operands / iteration counts, requester k at slice k
//   ack_o           pulse: operand captured
//   resp_valid_o    pulse: resp_y_o valid for that requester
//   resp_y_o        result, held until the next response
//   resp_err_o      1 = watchdog abort (0 when the watchdog is not built)
//   grant_id_o      current / last granted index
//   arb_busy_o      high outside IDLE
//   approx_start_o  one-cycle start to the unit
//   approx_x_o      operand to the unit
//   approx_nit_o    iteration count to the unit
//   approx_busy_i   unit busy (blocks new grants)
//   approx_valid_i  unit result pulse, honoured only in WAIT
//   approx_y_i      unit result
module approx_arbiter
  import approx_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned IT_W        = IT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   x_i,
  input  logic [NUM_REQ*IT_W-1:0]     nit_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic [NUM_REQ-1:0]          resp_valid_o,
  output logic [DATA_W-1:0]           resp_y_o,
  output logic                        resp_err_o,
  output logic [clog2(NUM_REQ)-1:0]   grant_id_o,
  output logic                        arb_busy_o,
  output logic                        approx_start_o,
  output logic [DATA_W-1:0]           approx_x_o,
  output logic [IT_W-1:0]             approx_nit_o,
  input  logic                        approx_busy_i,
  input  logic                        approx_valid_i,
  input  logic [DATA_W-1:0]           approx_y_i
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("approx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_y_q, resp_y_d;
  logic                arb_busy_q, arb_busy_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   ax_q, ax_d;
  logic [IT_W-1:0]     anit_q, anit_d;

`ifdef APPROX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resp_err_q, resp_err_d;
`endif

  logic [NUM_REQ-1:0]  win_gnt;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_c (win_gnt),
    .idx_c (win_idx),
    .any_c (win_any)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    ack_d        = '0;
    resp_valid_d = '0;
    resp_y_d     = resp_y_q;
    start_d      = 1'b0;
    ax_d         = ax_q;
    anit_d       = anit_q;
`ifdef APPROX_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_any && !approx_busy_i) begin
          state_d = S_ISSUE;
          ack_d   = win_gnt;
          grant_d = win_idx;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
              ax_d   = x_i[k*DATA_W +: DATA_W];
              anit_d = nit_i[k*IT_W +: IT_W];
            end
          end
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_WAIT;
`ifdef APPROX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // A result arriving on the final watchdog cycle still wins.
        if (approx_valid_i) begin
          resp_y_d = approx_y_i;
          state_d  = S_DELIVER;
`ifdef APPROX_ARB_TIMEOUT_EN
          resp_err_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          resp_y_d   = '0;
          resp_err_d = 1'b1;
          state_d    = S_DELIVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_DELIVER: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (grant_q == IDX_W'(k)) resp_valid_d[k] = 1'b1;
        end
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    arb_busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      ack_q        <= '0;
      resp_valid_q <= '0;
      resp_y_q     <= '0;
      arb_busy_q   <= 1'b0;
      start_q      <= 1'b0;
      ax_q         <= '0;
      anit_q       <= '0;
`ifdef APPROX_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= resp_y_d;
      arb_busy_q   <= arb_busy_d;
      start_q      <= start_d;
      ax_q         <= ax_d;
      anit_q       <= anit_d;
`ifdef APPROX_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign ack_o          = ack_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_y_o       = resp_y_q;
  assign grant_id_o     = grant_q;
  assign arb_busy_o     = arb_busy_q;
  assign approx_start_o = start_q;
  assign approx_x_o     = ax_q;
  assign approx_nit_o   = anit_q;
`ifdef APPROX_ARB_TIMEOUT_EN
  assign resp_err_o     = resp_err_q;
`else
  assign resp_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_approx_arbiter.sv
// tb_approx_arbiter: directed self-checking bench; the bench plays the approximation unit.
module tb_approx_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned IT_W        = 3;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] x_i;
  logic [NUM_REQ*IT_W-1:0]   nit_i;
  logic [NUM_REQ-1:0]        ack_o;
  logic [NUM_REQ-1:0]        resp_valid_o;
  logic [DATA_W-1:0]         resp_y_o;
  logic                      resp_err_o;
  logic [1:0]                grant_id_o;
  logic                      arb_busy_o;
  logic                      approx_start_o;
  logic [DATA_W-1:0]         approx_x_o;
  logic [IT_W-1:0]           approx_nit_o;
  logic                      approx_busy_i;
  logic                      approx_valid_i;
  logic [DATA_W-1:0]         approx_y_i;

  logic [DATA_W-1:0] xv [NUM_REQ];
  logic [IT_W-1:0]   nv [NUM_REQ];

  int checks;
  int failures;

  approx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .IT_W        (IT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .x_i            (x_i),
    .nit_i          (nit_i),
    .ack_o          (ack_o),
    .resp_valid_o   (resp_valid_o),
    .resp_y_o       (resp_y_o),
    .resp_err_o     (resp_err_o),
    .grant_id_o     (grant_id_o),
    .arb_busy_o     (arb_busy_o),
    .approx_start_o (approx_start_o),
    .approx_x_o     (approx_x_o),
    .approx_nit_o   (approx_nit_o),
    .approx_busy_i  (approx_busy_i),
    .approx_valid_i (approx_valid_i),
    .approx_y_i     (approx_y_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from an IDLE cycle with requests already presented.
  task automatic do_txn(input string tag, input logic [NUM_REQ-1:0] exp_ack,
                        input int max_wait, input bit hold, input logic [DATA_W-1:0] yv);
    bit got;
    int idx;
    got = 1'b0;
    idx = 0;
    for (int i = 0; i < max_wait; i++) begin
      step();
      if (ack_o != '0) begin
        got = 1'b1;
        break;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) if (exp_ack[k]) idx = k;
    check({tag, "_acked"}, 32'(got), 32'd1);
    check({tag, "_ack"}, 32'(ack_o), 32'(exp_ack));
    check({tag, "_grant"}, 32'(grant_id_o), 32'(idx));
    check({tag, "_busy"}, 32'(arb_busy_o), 32'd1);
    check({tag, "_start_early"}, 32'(approx_start_o), 32'd0);
    if (!hold) req_i = req_i & ~exp_ack;
    step();
    check({tag, "_start"}, 32'(approx_start_o), 32'd1);
    check({tag, "_ack_pulse"}, 32'(ack_o), 32'd0);
    check({tag, "_x"}, 32'(approx_x_o), 32'(xv[idx]));
    check({tag, "_nit"}, 32'(approx_nit_o), 32'(nv[idx]));
    step();
    check({tag, "_start_pulse"}, 32'(approx_start_o), 32'd0);
    approx_valid_i = 1'b1;
    approx_y_i     = yv;
    step();
    approx_valid_i = 1'b0;
    check({tag, "_resp_early"}, 32'(resp_valid_o), 32'd0);
    step();
    check({tag, "_resp"}, 32'(resp_valid_o), 32'(exp_ack));
    check({tag, "_y"}, 32'(resp_y_o), 32'(yv));
    check({tag, "_err"}, 32'(resp_err_o), 32'd0);
    check({tag, "_idle"}, 32'(arb_busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    xv[0] = 16'h1000; xv[1] = 16'h2222; xv[2] = 16'h3333; xv[3] = 16'h4444;
    nv[0] = 3'd3;     nv[1] = 3'd5;     nv[2] = 3'd0;     nv[3] = 3'd7;
    x_i   = {xv[3], xv[2], xv[1], xv[0]};
    nit_i = {nv[3], nv[2], nv[1], nv[0]};
    req_i          = '0;
    approx_busy_i  = 1'b0;
    approx_valid_i = 1'b0;
    approx_y_i     = '0;
    rst            = 1'b1;

    // Reset state
    step();
    step();
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_resp", 32'(resp_valid_o), 32'd0);
    check("rst_y", 32'(resp_y_o), 32'd0);
    check("rst_grant", 32'(grant_id_o), 32'd0);
    check("rst_busy", 32'(arb_busy_o), 32'd0);
    check("rst_start", 32'(approx_start_o), 32'd0);
    check("rst_x", 32'(approx_x_o), 32'd0);
    check("rst_nit", 32'(approx_nit_o), 32'd0);
    check("rst_err", 32'(resp_err_o), 32'd0);
    rst = 1'b0;

    // 1: single request
    req_i = 4'b0001;
    do_txn("t1", 4'b0001, 1, 1'b0, 16'h0800);

    // Reset in WAIT: outputs clear at once, no response; pointer back to 0
    req_i = 4'b0010;
    step();
    check("rmid_ack", 32'(ack_o), 32'h2);
    step();
    check("rmid_start", 32'(approx_start_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rmid_start0", 32'(approx_start_o), 32'd0);
    check("rmid_busy0", 32'(arb_busy_o), 32'd0);
    check("rmid_grant0", 32'(grant_id_o), 32'd0);
    check("rmid_y0", 32'(resp_y_o), 32'd0);
    check("rmid_x0", 32'(approx_x_o), 32'd0);
    req_i = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rmid_noresp", 32'(resp_valid_o), 32'd0);
      check("rmid_idle", 32'(arb_busy_o), 32'd0);
    end

    // 2: all requesting, strict rotation 0,1,2,3,0
    req_i = 4'b1111;
    do_txn("t2a", 4'b0001, 1, 1'b1, 16'h0101);
    do_txn("t2b", 4'b0010, 1, 1'b1, 16'h0202);
    do_txn("t2c", 4'b0100, 1, 1'b1, 16'h0303);
    do_txn("t2d", 4'b1000, 1, 1'b1, 16'h0404);
    do_txn("t2e", 4'b0001, 1, 1'b1, 16'h0505);
    req_i = '0;

    // 3: pointer at 1, requests 0 and 2 -> 2 first, then 0
    req_i = 4'b0101;
    do_txn("t3a", 4'b0100, 1, 1'b0, 16'hF00D);
    do_txn("t3b", 4'b0001, 1, 1'b0, 16'h8001);

    // 4: unit busy blocks the grant
    approx_busy_i = 1'b1;
    req_i         = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_blocked", 32'(ack_o), 32'd0);
      check("t4_idle", 32'(arb_busy_o), 32'd0);
    end
    approx_busy_i = 1'b0;
    do_txn("t4", 4'b0010, 1, 1'b0, 16'h0AAA);

    // 5: stray valids in IDLE and ISSUE are ignored
    approx_valid_i = 1'b1;
    approx_y_i     = 16'hDEAD;
    step();
    approx_valid_i = 1'b0;
    step();
    check("t5_idle_resp", 32'(resp_valid_o), 32'd0);
    check("t5_idle_y", 32'(resp_y_o), 32'h0AAA);
    check("t5_idle_busy", 32'(arb_busy_o), 32'd0);
    req_i = 4'b1000;
    step();
    check("t5_ack", 32'(ack_o), 32'h8);
    req_i          = '0;
    approx_valid_i = 1'b1;
    approx_y_i     = 16'hBEEF;
    step();
    approx_valid_i = 1'b0;
    check("t5_start", 32'(approx_start_o), 32'd1);
    step();
    check("t5_issue_resp", 32'(resp_valid_o), 32'd0);
    check("t5_wait_busy", 32'(arb_busy_o), 32'd1);
    approx_valid_i = 1'b1;
    approx_y_i     = 16'h1234;
    step();
    approx_valid_i = 1'b0;
    step();
    check("t5_resp", 32'(resp_valid_o), 32'h8);
    check("t5_y", 32'(resp_y_o), 32'h1234);

`ifdef APPROX_ARB_TIMEOUT_EN
    // 6: unit never answers -> abort after TIMEOUT_CYC WAIT cycles
    begin
      int n;
      n = 0;
      req_i = 4'b0001;
      step();
      check("t6_ack", 32'(ack_o), 32'h1);
      req_i = '0;
      step();
      check("t6_start", 32'(approx_start_o), 32'd1);
      for (int i = 1; i <= 40; i++) begin
        step();
        if (resp_valid_o != '0) begin
          n = i;
          break;
        end
      end
      check("t6_latency", 32'(n), 32'(TIMEOUT_CYC + 1));
      check("t6_resp", 32'(resp_valid_o), 32'h1);
      check("t6_y", 32'(resp_y_o), 32'd0);
      check("t6_err", 32'(resp_err_o), 32'd1);
      approx_valid_i = 1'b1;
      approx_y_i     = 16'h7777;
      step();
      approx_valid_i = 1'b0;
      step();
      step();
      check("t6_late_resp", 32'(resp_valid_o), 32'd0);
      check("t6_late_busy", 32'(arb_busy_o), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
